uart_rx_fifo: RTL

//  UART receiver (8N1, 16x oversampling) with a small first-word-fall-through FIFO.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_fifo.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and framing constants for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int HALF_BIT   = 8;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through byte FIFO; the head entry is always visible on o_head.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  // Extra pointer MSB tells full from empty when the low bits coincide.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_drop = i_push && o_full && !w_pop;
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small FWFT byte FIFO,
// with sticky frame-error and overrun flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 65,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       RxD,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV_W = $clog2(BAUD_DIV);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(HALF_BIT - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 r_rx_meta;
  logic                 r_rxs;
  logic [DIV_W-1:0]     r_div;
  logic                 w_tick;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [OS_W-1:0]      r_os_cnt;
  logic [OS_W-1:0]      w_os_nxt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BIT_W-1:0]     w_bit_nxt;
  logic                 w_div_clr;
  logic                 w_shift_en;
  logic                 w_push_stop;
  logic                 w_ferr_set;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_push_p1;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [7:0]           w_head;

  // Stage: input synchronizer (idles high so reset never looks like a start edge)
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= RxD;
      r_rxs     <= r_rx_meta;
    end
  end

  // Stage: oversample tick divider, realigned to each start edge
  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_div <= '0;
    end else if (w_div_clr || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Stage: framing FSM
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state   <= IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_os_cnt  <= w_os_nxt;
      r_bit_cnt <= w_bit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_div_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_push_stop = 1'b0;
    w_ferr_set  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_rxs) begin
          w_state_nxt = START;
          w_os_nxt    = '0;
          w_bit_nxt   = '0;
          w_div_clr   = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_os_cnt == OS_HALF) begin
            w_os_nxt    = '0;
            w_state_nxt = r_rxs ? IDLE : DATA;
          end else begin
            w_os_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_nxt   = '0;
            w_shift_en = 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
              w_bit_nxt   = '0;
              w_state_nxt = STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + BIT_W'(1);
            end
          end else begin
            w_os_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_nxt = '0;
            if (r_rxs) begin
              w_push_stop = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_ferr_set  = 1'b1;
              w_state_nxt = BREAK;
            end
          end else begin
            w_os_nxt = r_os_cnt + OS_W'(1);
          end
        end
      end
      BREAK: begin
        if (r_rxs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // LSB arrives first, so shift in from the top.
  always_ff @(posedge clock_in) begin
    if (w_shift_en) r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
  end

  // Stage: push one cycle after the stop sample; r_shift is stable until the next frame's data
  always_ff @(posedge clock_in) begin
    if (reset) r_push_p1 <= 1'b0;
    else       r_push_p1 <= w_push_stop;
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (clock_in),
    .i_rst   (reset),
    .i_push  (r_push_p1),
    .i_din   (r_shift),
    .i_pop   (rd_en),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop),
    .o_head  (w_head)
  );

  // Stage: sticky status; a set event outranks a simultaneous clear
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_ferr_set)   r_ferr <= 1'b1;
      else if (err_clr) r_ferr <= 1'b0;
      if (w_drop)       r_ovr  <= 1'b1;
      else if (err_clr) r_ovr  <= 1'b0;
    end
  end

  assign rx_data   = w_head;
  assign rx_valid  = !w_empty;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule
